univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/ureg_pkg.sv | 23 ++
 rtl/ureg_shift_unit.sv | 31 +++
 rtl/univ_shift_reg.sv | 95 +++++++++
 tb/tb_univ_shift_reg.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ureg_pkg.sv
// Shared mode encodings for the universal shift register and its bench.
package ureg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_CLR  = 3'b111
   } mode_e;

   localparam int MODE_W = 3;

   // True for every mode that moves bits by one position and advances the count.
   function automatic logic is_shift(input mode_e m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
             (m == MODE_ROR) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/ureg_shift_unit.sv
// Combinational next-value datapath for univ_shift_reg: load, shift, rotate, clear.
module ureg_shift_unit
   import ureg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic [WIDTH-1:0] cur,
   input  mode_e            mode,
   input  logic [WIDTH-1:0] din,
   input  logic             ser_l,
   input  logic             ser_r,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = cur;
      case (mode)
         MODE_HOLD: nxt = cur;
         MODE_LOAD: nxt = din;
         MODE_SHL:  nxt = {cur[WIDTH-2:0], ser_l};
         MODE_SHR:  nxt = {ser_r, cur[WIDTH-1:1]};
         MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
         MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         MODE_CLR:  nxt = RESET_VAL;
         default:   nxt = cur;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with saturating shift count and done flag.
// Optional registered even-parity output when UREG_PARITY_EN is defined.
module univ_shift_reg
   import ureg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       clear_n,
   input  logic                       en,
   input  logic [MODE_W-1:0]          mode,
   input  logic [WIDTH-1:0]           IN,
   input  logic                       ser_l,
   input  logic                       ser_r,
   output logic [WIDTH-1:0]           OUT,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       done
`ifdef UREG_PARITY_EN
   ,
   output logic                       parity
`endif
);

   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   mode_e            mode_sel;
   logic [WIDTH-1:0] nxt_val;
   logic [WIDTH-1:0] out_d, out_q;
   logic [CW-1:0]    cnt_d, cnt_q;
   logic             done_d, done_q;

   assign mode_sel = mode_e'(mode);

   ureg_shift_unit #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_shift_unit (
      .cur   (out_q),
      .mode  (mode_sel),
      .din   (IN),
      .ser_l (ser_l),
      .ser_r (ser_r),
      .nxt   (nxt_val)
   );

   always_comb begin
      out_d  = out_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      if (en) begin
         if (mode_sel == MODE_LOAD || mode_sel == MODE_CLR) begin
            out_d  = nxt_val;
            cnt_d  = '0;
            done_d = 1'b0;
         end else if (is_shift(mode_sel)) begin
            out_d  = nxt_val;
            // Count saturates so done stays asserted through extra shifts.
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            done_d = (cnt_d == CNT_MAX);
         end
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         out_q  <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign OUT  = out_q;
   assign cnt  = cnt_q;
   assign done = done_q;

`ifdef UREG_PARITY_EN
   logic parity_d, parity_q;

   assign parity_d = ^out_d;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) parity_q <= ^RESET_VAL;
      else          parity_q <= parity_d;
   end

   assign parity = parity_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed vector bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_shift_reg;
   import ureg_pkg::*;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       en;
   logic [2:0] mode;
   logic [7:0] din;
   logic       ser_l, ser_r;
   logic [7:0] dout;
   logic [3:0] cnt;
   logic       done;
`ifdef UREG_PARITY_EN
   logic       parity;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic       en;
      mode_e      mode;
      logic [7:0] din;
      logic       ser_l;
      logic       ser_r;
      logic [7:0] exp_out;
      logic [3:0] exp_cnt;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .en      (en),
      .mode    (mode),
      .IN      (din),
      .ser_l   (ser_l),
      .ser_r   (ser_r),
      .OUT     (dout),
      .cnt     (cnt),
      .done    (done)
`ifdef UREG_PARITY_EN
      ,
      .parity  (parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic add(input logic e, input mode_e m, input logic [7:0] d, input logic sl,
                      input logic sr, input logic [7:0] eo, input logic [3:0] ec, input logic ed);
      vec_t v;
      v.en = e; v.mode = m; v.din = d; v.ser_l = sl; v.ser_r = sr;
      v.exp_out = eo; v.exp_cnt = ec; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic step(input logic e, input mode_e m, input logic [7:0] d, input logic sl,
                       input logic sr);
      en = e; mode = m; din = d; ser_l = sl; ser_r = sr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // en, mode, IN, ser_l, ser_r -> OUT, cnt, done
      add(1, MODE_LOAD, 8'hAA, 0, 0, 8'hAA, 0, 0);
      add(1, MODE_SHL,  8'h00, 1, 0, 8'h55, 1, 0);
      add(1, MODE_SHR,  8'h00, 0, 1, 8'hAA, 2, 0);
      add(1, MODE_ROL,  8'h00, 0, 0, 8'h55, 3, 0);
      add(1, MODE_HOLD, 8'hFF, 1, 1, 8'h55, 3, 0);
      add(0, MODE_LOAD, 8'hFF, 1, 1, 8'h55, 3, 0);
      add(0, MODE_LOAD, 8'hFF, 1, 1, 8'h55, 3, 0);
      add(0, MODE_LOAD, 8'hFF, 1, 1, 8'h55, 3, 0);
      add(1, MODE_CLR,  8'hFF, 0, 0, 8'h00, 0, 0);
      add(1, MODE_LOAD, 8'h80, 0, 0, 8'h80, 0, 0);
      add(1, MODE_ASR,  8'h00, 0, 0, 8'hC0, 1, 0);
      add(1, MODE_ASR,  8'h00, 0, 0, 8'hE0, 2, 0);
      add(1, MODE_SHR,  8'h00, 1, 0, 8'h70, 3, 0);
      add(1, MODE_LOAD, 8'h81, 0, 0, 8'h81, 0, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'hC0, 1, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h60, 2, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h30, 3, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h18, 4, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h0C, 5, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h06, 6, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h03, 7, 0);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'h81, 8, 1);
      add(1, MODE_ROR,  8'h00, 1, 1, 8'hC0, 8, 1);
      add(1, MODE_HOLD, 8'h00, 0, 0, 8'hC0, 8, 1);
      add(1, MODE_SHL,  8'h00, 0, 0, 8'h80, 8, 1);
      add(0, MODE_CLR,  8'h00, 0, 0, 8'h80, 8, 1);
      add(1, MODE_LOAD, 8'h07, 0, 0, 8'h07, 0, 0);
      add(1, MODE_SHL,  8'h00, 0, 0, 8'h0E, 1, 0);
      add(1, MODE_LOAD, 8'h03, 0, 0, 8'h03, 0, 0);

      clear_n = 1'b0; en = 1'b0; mode = MODE_HOLD; din = '0; ser_l = 0; ser_r = 0;
      #2;
      check("reset out",  64'(dout), 64'h00);
      check("reset cnt",  64'(cnt),  64'h0);
      check("reset done", 64'(done), 64'h0);
`ifdef UREG_PARITY_EN
      check("reset parity", 64'(parity), 64'h0);
`endif
      #5 clear_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].mode, vecs[i].din, vecs[i].ser_l, vecs[i].ser_r);
         check($sformatf("v%0d out", i),  64'(dout), 64'(vecs[i].exp_out));
         check($sformatf("v%0d cnt", i),  64'(cnt),  64'(vecs[i].exp_cnt));
         check($sformatf("v%0d done", i), 64'(done), 64'(vecs[i].exp_done));
`ifdef UREG_PARITY_EN
         check($sformatf("v%0d parity", i), 64'(parity), 64'(^vecs[i].exp_out));
`endif
      end

      // Asynchronous clear in the middle of a rotate sequence.
      step(1, MODE_LOAD, 8'h01, 0, 0);
      step(1, MODE_ROL,  8'h00, 0, 0);
      step(1, MODE_ROL,  8'h00, 0, 0);
      check("rol pre-clear out", 64'(dout), 64'h04);
      check("rol pre-clear cnt", 64'(cnt),  64'h2);
      #2 clear_n = 1'b0;
      #1;
      check("async clr out",  64'(dout), 64'h00);
      check("async clr cnt",  64'(cnt),  64'h0);
      check("async clr done", 64'(done), 64'h0);
`ifdef UREG_PARITY_EN
      check("async clr parity", 64'(parity), 64'h0);
`endif
      #2 clear_n = 1'b1;
      step(1, MODE_SHL, 8'h00, 1, 0);
      check("post-clr shl out", 64'(dout), 64'h01);
      check("post-clr shl cnt", 64'(cnt),  64'h1);
      check("post-clr shl done", 64'(done), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
